// File: rtl/rand_pkg.sv
// rand_pkg: shared FSM states, span helper and parameter legality checks for lfsr_range_rand.
package rand_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, REDUCE, OUT} state_t;

    function automatic longint span_of(input longint mn, input longint mx);
        return mx - mn + 1;
    endfunction

    function automatic bit shifts_ok(input int s);
        return s >= 1;
    endfunction

    function automatic bit range_ok(input longint mn, input longint mx, input int w);
        return (mn >= 0) && (mn <= mx) && (mx < (longint'(1) << w));
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: free-running Fibonacci LFSR with run-time seed load; a zero seed becomes all-ones.
module lfsr_core #(
    parameter int              WIDTH = 10,
    parameter logic [WIDTH-1:0] TAPS = 10'h240
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] w_nxt;

    always_comb w_nxt = seed_load ? ((seed == '0) ? '1 : seed) : {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};

    always_ff @(posedge clk) begin
        if (rst) r_lfsr <= '1;
        else     r_lfsr <= w_nxt;
    end

    assign state = r_lfsr;

endmodule

// File: rtl/lfsr_range_rand.sv
// lfsr_range_rand: LFSR random source delivering one value in [RANGE_MIN, RANGE_MAX] per request,
// reduced by repeated subtraction of the span instead of a divider.
module lfsr_range_rand
    import rand_pkg::*;
#(
    parameter int               WIDTH     = 10,
    parameter logic [WIDTH-1:0] TAPS      = 10'h240,
    parameter int               SHIFTS    = 10,
    parameter longint           RANGE_MIN = 0,
    parameter longint           RANGE_MAX = 540
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             req,
    output logic             busy,
    output logic [WIDTH-1:0] rnd,
    output logic             rnd_valid,
    input  logic             rnd_ready
);

    localparam int             CW   = $clog2(SHIFTS + 1);
    localparam logic [WIDTH:0] SPAN = (WIDTH+1)'(span_of(RANGE_MIN, RANGE_MAX));

    if (!shifts_ok(SHIFTS)) begin : g_bad_shifts
        $error("lfsr_range_rand: SHIFTS must be >= 1");
    end
    if (!range_ok(RANGE_MIN, RANGE_MAX, WIDTH)) begin : g_bad_range
        $error("lfsr_range_rand: need 0 <= RANGE_MIN <= RANGE_MAX <= 2^WIDTH-1");
    end

    state_t           r_state, w_state;
    logic [CW-1:0]    r_cnt, w_cnt;
    logic [WIDTH:0]   r_acc, w_acc, w_opd;
    logic [WIDTH-1:0] r_rnd, w_rnd;
    logic             r_valid, w_valid;
    logic [WIDTH-1:0] w_lfsr;

    lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS)) u_core (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed      (seed),
        .state     (w_lfsr)
    );

    // First REDUCE cycle (cnt still nonzero) works on the value the LFSR took at the capture edge.
    assign w_opd = (r_cnt != '0) ? {1'b0, w_lfsr} : r_acc;

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_acc   = r_acc;
        w_rnd   = r_rnd;
        w_valid = r_valid;
        case (r_state)
            IDLE: if (req) begin
                w_state = WAIT;
                w_cnt   = CW'(1);
            end
            WAIT: if (r_cnt == CW'(SHIFTS)) w_state = REDUCE;
                  else                      w_cnt   = r_cnt + 1'b1;
            REDUCE: begin
                w_cnt = '0;
                if (w_opd >= SPAN) w_acc = w_opd - SPAN;
                else begin
                    w_acc   = w_opd;
                    w_rnd   = w_opd[WIDTH-1:0] + WIDTH'(RANGE_MIN);
                    w_valid = 1'b1;
                    w_state = OUT;
                end
            end
            OUT: if (rnd_ready) begin
                w_valid = 1'b0;
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_rnd   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_acc   <= w_acc;
            r_rnd   <= w_rnd;
            r_valid <= w_valid;
        end
    end

    assign busy      = (r_state != IDLE);
    assign rnd       = r_rnd;
    assign rnd_valid = r_valid;

endmodule
